// File: rtl/mem_interface_pkg.sv
// Shared definitions for the RAM-side initiator: state encoding and default
// word/array sizes matching the attached ram block.
package mem_interface_pkg;

  localparam int unsigned DefBits    = 32;
  localparam int unsigned DefRamSize = 512;

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StRdIssue   = 3'd1,
    StRdCapture = 3'd2,
    StWrIssue   = 3'd3,
    StDone      = 3'd4
  } state_e;

endpackage

// File: rtl/mem_interface.sv
// MAR/MDR holder that turns single-cycle control-unit requests into timed
// ram read/write strobes, absorbing the RAM's one-cycle registered read latency.
module mem_interface
  import mem_interface_pkg::*;
#(
  parameter int unsigned BITS    = DefBits,
  parameter int unsigned RAMSIZE = DefRamSize,
  parameter int unsigned ADDR    = $clog2(RAMSIZE)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [BITS-1:0] bus_in,
  input  logic            mar_in,
  input  logic            mdr_in,
  input  logic            mem_rd,
  input  logic            mem_wr,
  input  logic [BITS-1:0] ram_data_in,
  output logic            ram_read,
  output logic            ram_write,
  output logic [ADDR-1:0] ram_addr,
  output logic [BITS-1:0] ram_data_out,
  output logic [ADDR-1:0] mar_out,
  output logic [BITS-1:0] mdr_out,
  output logic            busy,
  output logic            done,
  output logic            err
);

  state_e          state_q, state_d;
  logic [ADDR-1:0] mar_q, mar_d;
  logic [BITS-1:0] mdr_q, mdr_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      mar_q   <= '0;
      mdr_q   <= '0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mar_d     = mar_q;
    mdr_d     = mdr_q;
    ram_read  = 1'b0;
    ram_write = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mar_in) mar_d = bus_in[ADDR-1:0];
        if (mdr_in) mdr_d = bus_in;
        // Conflicting request is rejected outright; no RAM access is started.
        if (mem_rd && mem_wr) begin
          err = !reset;
        end else if (mem_rd) begin
          state_d = StRdIssue;
        end else if (mem_wr) begin
          state_d = StWrIssue;
        end
      end
      StRdIssue: begin
        ram_read = 1'b1;
        busy     = 1'b1;
        state_d  = StRdCapture;
      end
      StRdCapture: begin
        busy    = 1'b1;
        mdr_d   = ram_data_in;
        state_d = StDone;
      end
      StWrIssue: begin
        ram_write = 1'b1;
        busy      = 1'b1;
        state_d   = StDone;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign ram_addr     = mar_q;
  assign ram_data_out = mdr_q;
  assign mar_out      = mar_q;
  assign mdr_out      = mdr_q;

endmodule

// File: doc/mem_interface.md
# mem_interface

Memory-side initiator for the single-port `ram` block: holds the MAR and MDR, turns one-cycle read/write requests from the control unit into correctly timed `read`/`write` strobes, and captures returned data. It sits between the CPU data bus/control unit and `ram`, absorbing the RAM's registered one-cycle read latency behind a busy/done handshake.

## Interface
- `BITS`, 32, data word width (matches `ram`)
- `RAMSIZE`, 512, words in attached RAM
- `ADDR`, $clog2(RAMSIZE), RAM address width
- `clk`  in  1  single clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `bus_in`  in  BITS  CPU bus value for MAR/MDR loads
- `mar_in`  in  1  load MAR from `bus_in[ADDR-1:0]`
- `mdr_in`  in  1  load MDR from `bus_in`
- `mem_rd`  in  1  request read at MAR into MDR
- `mem_wr`  in  1  request write of MDR to MAR
- `ram_data_in`  in  BITS  from `ram.dataOut`
- `ram_read`  out  1  to `ram.read`
- `ram_write`  out  1  to `ram.write`
- `ram_addr`  out  ADDR  to `ram.address`
- `ram_data_out`  out  BITS  to `ram.dataIn`
- `mar_out`  out  ADDR  current MAR
- `mdr_out`  out  BITS  current MDR (drives CPU bus)
- `busy`  out  1  transaction in progress
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  one-cycle pulse: illegal request

## Operation
- States: IDLE, RD_ISSUE, RD_CAPTURE, WR_ISSUE, DONE.
- IDLE: `mar_in`/`mdr_in` load registers; both may assert together. `mem_rd` alone -> RD_ISSUE; `mem_wr` alone -> WR_ISSUE; both -> stay IDLE, pulse `err`, no RAM access.
- RD_ISSUE: `ram_read`=1, `ram_write`=0 -> RD_CAPTURE.
- RD_CAPTURE: strobes 0; MDR <= `ram_data_in` at cycle end -> DONE.
- WR_ISSUE: `ram_write`=1, `ram_read`=0 -> DONE.
- DONE: `done`=1, `busy`=0 -> IDLE. Requests in DONE are ignored.
- `ram_read` and `ram_write` are never 1 together.
- `busy`=1 in RD_ISSUE, RD_CAPTURE, WR_ISSUE.
- `ram_addr` = MAR and `ram_data_out` = MDR at all times (combinational).
- While `busy` or in DONE: `mar_in`, `mdr_in`, `mem_rd`, `mem_wr` ignored; MAR/MDR frozen except read capture.
- MAR takes low ADDR bits of bus; upper bits discarded. No address translation; out-of-range impossible by width.

## Timing
- Reset: state IDLE, MAR=0, MDR=0, `ram_read`=0, `ram_write`=0, `busy`=0, `done`=0, `err`=0.
- Reset mid-transaction: next edge returns to IDLE with all outputs at reset values; pending read data discarded; a WR_ISSUE cycle coincident with reset still strobes `ram_write` that cycle (RAM sees the edge), which is accepted behaviour.
- Read: `mem_rd` sampled at edge E0; `ram_read` high E0–E1; RAM output valid after E1; MDR updated at E2; `done` high E2–E3. Request-to-done latency 3 edges.
- Write: `mem_wr` sampled at E0; `ram_write` high E0–E1; RAM updated at E1; `done` high E1–E2. Latency 2 edges.
- Back-to-back: next request accepted earliest in IDLE, i.e. the cycle after `done`.
- Requests are level-sampled only in IDLE; control unit holds or pulses, no queuing.

## Structure
- Shared package: state encoding constants (IDLE=0, RD_ISSUE=1, RD_CAPTURE=2, WR_ISSUE=3, DONE=4, 3-bit), BITS/RAMSIZE defaults shared with `ram`.
- Single module; no sub-module required. A `mem_subsystem` wrapper instantiating `mem_interface` + `ram` is built for verification only.

## Test plan
- Reset then idle: all outputs 0, `mar_out`=0, `mdr_out`=0, no strobes for 10 cycles.
- Write/read-back: load MAR=85, MDR='h0000f7f7, `mem_wr` -> `ram_write` one cycle, `done` at +2; clear MDR, `mem_rd` -> `ram_read` one cycle, `mdr_out`='h0000f7f7 and `done` at +3.
- Truncation: bus='hFFFF_FE04 with `mar_in` -> `mar_out`=4; read returns RAM[4].
- Simultaneous `mem_rd`+`mem_wr` in IDLE -> `err` pulse, no strobes, state stays IDLE.
- Ignore-while-busy: during read, pulse `mar_in` (bus=7), `mdr_in`, `mem_wr` -> MAR unchanged, no write strobe, only one `done`.
- Reset asserted in RD_CAPTURE -> next cycle IDLE, MDR=0, no `done` pulse.
